multiplicador_seq: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the responder side of the RAM controller's calculation handshake.
- The RAM controller reads both operands, pulses the start request and waits for end-of-multiplication. This block latches the operands, iterates one multiplier bit per clock and returns the product with a single-cycle done pulse.
- It sits between the RAM controller FSM and the RAM write-back path.

---
 rtl/multiplicador_seq.sv | 89 ++++++++
 tb/tb_multiplicador_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// Sequential unsigned shift-add multiplier answering the RAM controller's start/end handshake.
// It latches both operands, iterates one multiplier bit per clock and returns the product with a one-cycle done pulse.
module multiplicador_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 end_mult_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_MUL_IDLE = 2'd0,
        ST_MUL_LOAD = 2'd1,
        ST_MUL_CALC = 2'd2,
        ST_MUL_DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [CW-1:0]          cnt_reg;
    logic [2*WIDTH-1:0]     product_reg;
    logic                   end_mult_reg;
    logic [2*WIDTH-1:0]     acc_next;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_MUL_IDLE;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            product_reg  <= '0;
            end_mult_reg <= 1'b0;
        end else begin
            end_mult_reg <= 1'b0;
            case (state_reg)
                ST_MUL_IDLE: begin
                    if (start_i) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, a_i};
                        mplier_reg <= b_i;
                        state_reg  <= ST_MUL_LOAD;
                    end
                end
                ST_MUL_LOAD: begin
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= ST_MUL_CALC;
                end
                ST_MUL_CALC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Fixed latency: always run all WIDTH iterations, even on a zero multiplier.
                    if (cnt_reg == LAST_ITER) begin
                        product_reg  <= acc_next;
                        end_mult_reg <= 1'b1;
                        state_reg    <= ST_MUL_DONE;
                    end
                end
                ST_MUL_DONE: begin
                    state_reg <= ST_MUL_IDLE;
                end
                default: begin
                    state_reg <= ST_MUL_IDLE;
                end
            endcase
        end
    end

    assign product_o  = product_reg;
    assign end_mult_o = end_mult_reg;
    assign busy_o     = (state_reg != ST_MUL_IDLE);
    assign state_o    = state_reg;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed-vector bench for multiplicador_seq (WIDTH=8) with a small procedural RAM controller model.
module tb_multiplicador_seq;

    localparam int WIDTH = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [2*WIDTH-1:0]   product_o;
    logic                 end_mult_o;
    logic                 busy_o;
    logic [1:0]           state_o;

    int n_checks = 0;
    int n_fail   = 0;

    multiplicador_seq #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .product_o  (product_o),
        .end_mult_o (end_mult_o),
        .busy_o     (busy_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Advance until end_mult_o is seen (bounded); cycle 1 is the cycle right after the accepting edge.
    task automatic wait_end(input int c0, output int cyc);
        cyc = c0;
        while (end_mult_o !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        int cyc;
        a_i = a; b_i = b; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, "_load_state"}, 32'(state_o), 32'd1);
        chk({tag, "_busy_c1"}, 32'(busy_o), 32'd1);
        wait_end(1, cyc);
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_product"}, 32'(product_o), 32'(exp));
        chk({tag, "_done_state"}, 32'(state_o), 32'd3);
        chk({tag, "_busy_c10"}, 32'(busy_o), 32'd1);
        tick();
        chk({tag, "_pulse_width"}, 32'(end_mult_o), 32'd0);
        chk({tag, "_product_hold"}, 32'(product_o), 32'(exp));
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
        $display("mult %s a=%0d b=%0d product=%0d latency=%0d", tag, a, b, product_o, cyc);
    endtask

    initial begin
        int cyc;
        int np;
        int pulses[4];
        int extra;
        logic [7:0]  mem [0:2];
        logic [15:0] stored;

        rst_i = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_product", 32'(product_o), 32'd0);
        chk("rst_end", 32'(end_mult_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        #20;
        rst_i = 1'b1;
        tick();
        $display("reset released");

        do_mult("m13x11", 8'd13, 8'd11, 16'd143);
        do_mult("m255x255", 8'd255, 8'd255, 16'hFE01);
        do_mult("m0x200", 8'd0, 8'd200, 16'd0);
        do_mult("m200x1", 8'd200, 8'd1, 16'd200);

        // Second start during CALC, with new operands, must be ignored.
        a_i = 8'd7; b_i = 8'd9; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        chk("ign_calc_state", 32'(state_o), 32'd2);
        a_i = 8'd50; b_i = 8'd50; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_end(4, cyc);
        chk("ign_latency", cyc, 10);
        chk("ign_product", 32'(product_o), 32'd63);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (end_mult_o) extra++;
        end
        chk("ign_single_pulse", extra, 0);
        chk("ign_product_hold", 32'(product_o), 32'd63);
        $display("mult ignored-start a=7 b=9 product=%0d extra_pulses=%0d", product_o, extra);

        // start_i held high: back-to-back operations every WIDTH+3 cycles.
        a_i = 8'd3; b_i = 8'd5; start_i = 1'b1;
        np = 0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (end_mult_o) begin
                if (np < 4) pulses[np] = i;
                np++;
                chk("held_product", 32'(product_o), 32'd15);
            end
        end
        start_i = 1'b0;
        chk("held_npulses", np, 3);
        chk("held_first", pulses[0], 10);
        chk("held_gap1", pulses[1] - pulses[0], 11);
        chk("held_gap2", pulses[2] - pulses[1], 11);
        $display("mult held-start a=3 b=5 pulses=%0d first=%0d", np, pulses[0]);
        for (int i = 0; i < 12; i++) tick();
        chk("held_back_idle", 32'(state_o), 32'd0);

        // Asynchronous reset during CALC iteration 4 aborts the operation.
        a_i = 8'd100; b_i = 8'd100; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_calc_state", 32'(state_o), 32'd2);
        chk("abort_prev_product", 32'(product_o), 32'd15);
        rst_i = 1'b0;
        #1;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_product", 32'(product_o), 32'd0);
        chk("abort_end", 32'(end_mult_o), 32'd0);
        tick();
        rst_i = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (end_mult_o || busy_o) extra++;
        end
        chk("abort_no_pulse", extra, 0);
        $display("mult aborted a=100 b=100 product=%0d", product_o);
        do_mult("m2x3", 8'd2, 8'd3, 16'd6);

        // RAM controller handshake model: read operands, pulse start, wait, store, idle.
        mem[0] = 8'd12; mem[1] = 8'd21; mem[2] = 8'd0;
        stored = '0;
        a_i = mem[0]; b_i = mem[1];
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_end(1, cyc);
        chk("ctl_end_seen", 32'(end_mult_o), 32'd1);
        tick();
        stored = product_o;
        mem[2] = stored[7:0];
        chk("ctl_stored", 32'(stored), 32'd252);
        chk("ctl_mem_lsb", 32'(mem[2]), 32'd252);
        tick(); tick();
        chk("ctl_dut_idle", 32'(state_o), 32'd0);
        chk("ctl_product_hold", 32'(product_o), 32'd252);
        $display("ctl handshake a=%0d b=%0d stored=%0d", mem[0], mem[1], stored);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
